// File: rtl/wdt_multi_ch_if.sv
// Register-decoder bus and interrupt lines of the multi-channel watchdog.
// The master drives the write strobes and kicks; the slave is the watchdog itself.
interface wdt_multi_ch_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int PRE_W  = 8,
    parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [SEL_W-1:0]  ch_sel;
    logic              en_wr;
    logic              en_val;
    logic              thr_wr;
    logic              warn_wr;
    logic [CNT_W-1:0]  wdata;
    logic              pre_wr;
    logic [PRE_W-1:0]  pre_val;
    logic [NUM_CH-1:0] kick;
    logic [NUM_CH-1:0] wto_irq;
    logic [NUM_CH-1:0] warn_irq;
    logic [NUM_CH-1:0] expired;

    modport master (
        output ch_sel, en_wr, en_val, thr_wr, warn_wr, wdata, pre_wr, pre_val, kick,
        input  wto_irq, warn_irq, expired
    );

    modport slave (
        input  ch_sel, en_wr, en_val, thr_wr, warn_wr, wdata, pre_wr, pre_val, kick,
        output wto_irq, warn_irq, expired
    );
endinterface

// File: rtl/wdt_multi_ch.sv
// Multi-channel watchdog with shared prescaler; counting in clk2, interrupts synchronised into clk.
// Optional macro WDT_LOCK_EN: channels lock once running, blocking disable/threshold/prescaler writes.
module wdt_multi_ch #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int PRE_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic          clk2,
    input logic          rst2,
    input logic          clk,
    input logic          rst,
    wdt_multi_ch_if.slave bus
);
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W:0] INC_ONE = (CNT_W+1)'(1);

    typedef enum logic [1:0] {DISABLED, RUNNING, EXPIRED} state_t;

    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];
    logic [CNT_W:0]    cnt_inc [NUM_CH];
    logic [CNT_W-1:0]  thr_q   [NUM_CH];
    logic [CNT_W-1:0]  warn_thr_q [NUM_CH];
    logic [NUM_CH-1:0] warn_q, warn_d;
    logic [NUM_CH-1:0] lock_q;
    logic [NUM_CH-1:0] sel_hit, ena_req, dis_req, thr_we, warn_we;
    logic [NUM_CH-1:0] expired_vec;
    logic [PRE_W-1:0]  pre_reload_q, pre_cnt_q;
    logic              pre_we;
    logic              tick;

`ifdef WDT_LOCK_EN
    always_ff @(posedge clk2 or posedge rst2) begin
        if (rst2) begin
            lock_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (state_d[i] == RUNNING) lock_q[i] <= 1'b1;
        end
    end
    assign pre_we = bus.pre_wr && (lock_q == '0);
`else
    assign lock_q = '0;
    assign pre_we = bus.pre_wr;
`endif

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sel_hit[i] = (bus.ch_sel == SEL_W'(i));
            ena_req[i] = bus.en_wr && bus.en_val && sel_hit[i];
            dis_req[i] = bus.en_wr && !bus.en_val && sel_hit[i] && !lock_q[i];
            thr_we[i]  = bus.thr_wr && sel_hit[i] && !lock_q[i];
            warn_we[i] = bus.warn_wr && sel_hit[i] && !lock_q[i];
        end
    end

    // Prescaler: tick while the down-counter sits at zero
    assign tick = (pre_cnt_q == '0);

    always_ff @(posedge clk2 or posedge rst2) begin
        if (rst2) begin
            pre_reload_q <= '0;
            pre_cnt_q    <= '0;
        end else if (pre_we) begin
            pre_reload_q <= bus.pre_val;
            pre_cnt_q    <= bus.pre_val;
        end else if (tick) begin
            pre_cnt_q <= pre_reload_q;
        end else begin
            pre_cnt_q <= pre_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk2 or posedge rst2) begin
        if (rst2) begin
            for (int i = 0; i < NUM_CH; i++) begin
                thr_q[i]      <= '1;
                warn_thr_q[i] <= '1;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (thr_we[i])  thr_q[i]      <= bus.wdata;
                if (warn_we[i]) warn_thr_q[i] <= bus.wdata;
            end
        end
    end

    // Channel FSMs: disable beats kick, kick beats tick
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            warn_d[i]  = warn_q[i];
            cnt_inc[i] = {1'b0, cnt_q[i]} + INC_ONE;
            case (state_q[i])
                DISABLED: begin
                    if (ena_req[i]) begin
                        state_d[i] = RUNNING;
                        cnt_d[i]   = '0;
                    end
                end
                RUNNING: begin
                    if (bus.kick[i]) begin
                        cnt_d[i]  = '0;
                        warn_d[i] = 1'b0;
                    end else if (tick) begin
                        if (cnt_inc[i] >= {1'b0, thr_q[i]}) begin
                            state_d[i] = EXPIRED;
                            cnt_d[i]   = thr_q[i];
                        end else begin
                            cnt_d[i] = cnt_inc[i][CNT_W-1:0];
                        end
                    end
                end
                EXPIRED: begin
                    if (bus.kick[i]) begin
                        state_d[i] = RUNNING;
                        cnt_d[i]   = '0;
                        warn_d[i]  = 1'b0;
                    end
                end
                default: state_d[i] = DISABLED;
            endcase
            if (dis_req[i]) begin
                state_d[i] = DISABLED;
                cnt_d[i]   = '0;
                warn_d[i]  = 1'b0;
            end
            // Expiry always implies warning, so a warn_thr >= thr still fires at expiry
            if ((state_d[i] == EXPIRED) ||
                ((state_d[i] == RUNNING) && (cnt_d[i] >= warn_thr_q[i])))
                warn_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk2 or posedge rst2) begin
        if (rst2) begin
            warn_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= DISABLED;
                cnt_q[i]   <= '0;
            end
        end else begin
            warn_q <= warn_d;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        expired_vec = '0;
        for (int i = 0; i < NUM_CH; i++)
            expired_vec[i] = (state_q[i] == EXPIRED);
    end

    assign bus.expired = expired_vec;

    // Level synchronisers into the clk domain
    logic [NUM_CH-1:0] wto_sync_p  [SYNC_STAGES];
    logic [NUM_CH-1:0] warn_sync_p [SYNC_STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                wto_sync_p[k]  <= '0;
                warn_sync_p[k] <= '0;
            end
        end else begin
            wto_sync_p[0]  <= expired_vec;
            warn_sync_p[0] <= warn_q;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                wto_sync_p[k]  <= wto_sync_p[k-1];
                warn_sync_p[k] <= warn_sync_p[k-1];
            end
        end
    end

    assign bus.wto_irq  = wto_sync_p[SYNC_STAGES-1];
    assign bus.warn_irq = warn_sync_p[SYNC_STAGES-1];
endmodule

// File: tb/tb_wdt_multi_ch.sv
// Directed self-checking bench for wdt_multi_ch (default parameters).
module tb_wdt_multi_ch;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;
    localparam int PRE_W  = 8;
    localparam logic [CNT_W-1:0] ONES = '1;

    logic clk2, rst2, clk, rst;
    int checks = 0;
    int errors = 0;

    wdt_multi_ch_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) bus ();

    wdt_multi_ch #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W), .SYNC_STAGES(2)) dut (
        .clk2 (clk2),
        .rst2 (rst2),
        .clk  (clk),
        .rst  (rst),
        .bus  (bus)
    );

    // clk2 rises at 10m+5, clk at 10k+7: clk always samples 2ns after clk2
    initial begin
        clk2 = 1'b0;
        forever #5 clk2 = ~clk2;
    end
    initial begin
        clk = 1'b0;
        #2;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk2);
        #1;
    endtask

    task automatic wr_thr(input int ch, input logic [CNT_W-1:0] v);
        bus.ch_sel = 2'(ch); bus.thr_wr = 1'b1; bus.wdata = v;
        cyc();
        bus.thr_wr = 1'b0;
    endtask

    task automatic wr_warn(input int ch, input logic [CNT_W-1:0] v);
        bus.ch_sel = 2'(ch); bus.warn_wr = 1'b1; bus.wdata = v;
        cyc();
        bus.warn_wr = 1'b0;
    endtask

    task automatic wr_en(input int ch, input logic v);
        bus.ch_sel = 2'(ch); bus.en_wr = 1'b1; bus.en_val = v;
        cyc();
        bus.en_wr = 1'b0;
    endtask

    task automatic wr_pre(input logic [PRE_W-1:0] v);
        bus.pre_wr = 1'b1; bus.pre_val = v;
        cyc();
        bus.pre_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst2 = 1'b1; rst = 1'b1;
        bus.ch_sel = '0; bus.en_wr = 1'b0; bus.en_val = 1'b0; bus.thr_wr = 1'b0;
        bus.warn_wr = 1'b0; bus.wdata = '0; bus.pre_wr = 1'b0; bus.pre_val = '0; bus.kick = '0;
        repeat (3) cyc();
        rst2 = 1'b0; rst = 1'b0;
        cyc();
        checks++;
        if (bus.expired !== 4'b0000) begin errors++; $display("FAIL reset_expired: got %b expected 0000", bus.expired); end
        checks++;
        if (bus.wto_irq !== 4'b0000 || bus.warn_irq !== 4'b0000) begin
            errors++; $display("FAIL reset_irq: got wto=%b warn=%b expected 0000", bus.wto_irq, bus.warn_irq);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            checks++;
            if (dut.thr_q[i] !== ONES || dut.warn_thr_q[i] !== ONES || dut.cnt_q[i] !== '0) begin
                errors++; $display("FAIL reset_ch%0d: got thr=%h warn=%h cnt=%h expected ffffffff ffffffff 0",
                                   i, dut.thr_q[i], dut.warn_thr_q[i], dut.cnt_q[i]);
            end
        end
        checks++;
        if (dut.pre_reload_q !== 8'd0) begin errors++; $display("FAIL reset_pre: got %h expected 0", dut.pre_reload_q); end
    endtask

    task automatic test_expire_basic();
        wr_thr(0, 10);
        wr_en(0, 1'b1);
        repeat (9) cyc();
        checks++;
        if (dut.cnt_q[0] !== 32'd9 || bus.expired[0] !== 1'b0 || dut.warn_q[0] !== 1'b0) begin
            errors++; $display("FAIL expire_pre: got cnt=%0d exp=%b warn=%b expected 9 0 0", dut.cnt_q[0], bus.expired[0], dut.warn_q[0]);
        end
        cyc();
        checks++;
        if (dut.cnt_q[0] !== 32'd10 || bus.expired[0] !== 1'b1 || dut.warn_q[0] !== 1'b1) begin
            errors++; $display("FAIL expire_at10: got cnt=%0d exp=%b warn=%b expected 10 1 1", dut.cnt_q[0], bus.expired[0], dut.warn_q[0]);
        end
        checks++;
        if (bus.wto_irq[0] !== 1'b0) begin errors++; $display("FAIL wto_lat0: got %b expected 0", bus.wto_irq[0]); end
        cyc();
        checks++;
        if (bus.wto_irq[0] !== 1'b0) begin errors++; $display("FAIL wto_lat1: got %b expected 0", bus.wto_irq[0]); end
        cyc();
        checks++;
        if (bus.wto_irq[0] !== 1'b1 || bus.warn_irq[0] !== 1'b1) begin
            errors++; $display("FAIL wto_lat2: got wto=%b warn=%b expected 1 1", bus.wto_irq[0], bus.warn_irq[0]);
        end
        repeat (3) cyc();
        checks++;
        if (dut.cnt_q[0] !== 32'd10) begin errors++; $display("FAIL expire_hold: got %0d expected 10", dut.cnt_q[0]); end
    endtask

    task automatic test_kick_expired();
        bus.kick = 4'b0001;
        cyc();
        bus.kick = '0;
        checks++;
        if (bus.expired[0] !== 1'b0 || dut.cnt_q[0] !== 32'd0 || dut.warn_q[0] !== 1'b0) begin
            errors++; $display("FAIL kick_exp: got exp=%b cnt=%0d warn=%b expected 0 0 0", bus.expired[0], dut.cnt_q[0], dut.warn_q[0]);
        end
        cyc();
        checks++;
        if (dut.cnt_q[0] !== 32'd1 || bus.wto_irq[0] !== 1'b1) begin
            errors++; $display("FAIL kick_restart: got cnt=%0d wto=%b expected 1 1", dut.cnt_q[0], bus.wto_irq[0]);
        end
        cyc();
        checks++;
        if (bus.wto_irq[0] !== 1'b0 || bus.warn_irq[0] !== 1'b0) begin
            errors++; $display("FAIL kick_irq_drop: got wto=%b warn=%b expected 0 0", bus.wto_irq[0], bus.warn_irq[0]);
        end
        wr_en(0, 1'b0);
        checks++;
        if (dut.cnt_q[0] !== 32'd0) begin errors++; $display("FAIL disable_ch0: got cnt=%0d expected 0", dut.cnt_q[0]); end
    endtask

    task automatic test_warning();
        wr_thr(1, 4);
        wr_warn(1, 2);
        bus.ch_sel = 2'd1; bus.en_wr = 1'b1; bus.en_val = 1'b1;
        bus.pre_wr = 1'b1; bus.pre_val = 8'd3;
        cyc();
        bus.en_wr = 1'b0; bus.pre_wr = 1'b0;
        repeat (3) cyc();
        checks++;
        if (dut.cnt_q[1] !== 32'd0) begin errors++; $display("FAIL pre_hold: got cnt=%0d expected 0", dut.cnt_q[1]); end
        cyc();
        checks++;
        if (dut.cnt_q[1] !== 32'd1) begin errors++; $display("FAIL pre_tick: got cnt=%0d expected 1", dut.cnt_q[1]); end
        repeat (3) cyc();
        checks++;
        if (dut.warn_q[1] !== 1'b0 || dut.cnt_q[1] !== 32'd1) begin
            errors++; $display("FAIL warn_early: got warn=%b cnt=%0d expected 0 1", dut.warn_q[1], dut.cnt_q[1]);
        end
        cyc();
        checks++;
        if (dut.warn_q[1] !== 1'b1 || dut.cnt_q[1] !== 32'd2) begin
            errors++; $display("FAIL warn_set: got warn=%b cnt=%0d expected 1 2", dut.warn_q[1], dut.cnt_q[1]);
        end
        cyc();
        checks++;
        if (bus.warn_irq[1] !== 1'b0) begin errors++; $display("FAIL warn_irq_lat: got %b expected 0", bus.warn_irq[1]); end
        cyc();
        checks++;
        if (bus.warn_irq[1] !== 1'b1) begin errors++; $display("FAIL warn_irq: got %b expected 1", bus.warn_irq[1]); end
        repeat (5) cyc();
        checks++;
        if (bus.expired[1] !== 1'b0 || dut.cnt_q[1] !== 32'd3) begin
            errors++; $display("FAIL warn_pre_exp: got exp=%b cnt=%0d expected 0 3", bus.expired[1], dut.cnt_q[1]);
        end
        cyc();
        checks++;
        if (bus.expired[1] !== 1'b1 || dut.cnt_q[1] !== 32'd4 || dut.warn_q[1] !== 1'b1) begin
            errors++; $display("FAIL warn_exp16: got exp=%b cnt=%0d warn=%b expected 1 4 1", bus.expired[1], dut.cnt_q[1], dut.warn_q[1]);
        end
        wr_en(1, 1'b0);
        checks++;
        if (bus.expired[1] !== 1'b0 || dut.warn_q[1] !== 1'b0 || dut.cnt_q[1] !== 32'd0) begin
            errors++; $display("FAIL warn_disable: got exp=%b warn=%b cnt=%0d expected 0 0 0", bus.expired[1], dut.warn_q[1], dut.cnt_q[1]);
        end
        wr_pre(8'd0);
    endtask

    task automatic test_kick_periodic();
        logic [CNT_W-1:0] exp_cnt;
        wr_thr(2, 5);
        wr_en(2, 1'b1);
        exp_cnt = '0;
        for (int k = 1; k <= 50; k++) begin
            bus.kick = (k % 4 == 0) ? 4'b0100 : 4'b0000;
            cyc();
            bus.kick = '0;
            exp_cnt = (k % 4 == 0) ? '0 : exp_cnt + 1;
            checks++;
            if (dut.cnt_q[2] !== exp_cnt || bus.expired[2] !== 1'b0) begin
                errors++; $display("FAIL kick_periodic k=%0d: got cnt=%0d exp=%b expected %0d 0", k, dut.cnt_q[2], bus.expired[2], exp_cnt);
            end
        end
        checks++;
        if (bus.wto_irq[2] !== 1'b0) begin errors++; $display("FAIL kick_periodic_irq: got %b expected 0", bus.wto_irq[2]); end
        wr_en(2, 1'b0);
    endtask

    task automatic test_priority();
        wr_en(3, 1'b1);
        repeat (3) cyc();
        checks++;
        if (dut.cnt_q[3] !== 32'd3) begin errors++; $display("FAIL prio_setup: got cnt=%0d expected 3", dut.cnt_q[3]); end
        bus.kick = 4'b1000; bus.ch_sel = 2'd3; bus.en_wr = 1'b1; bus.en_val = 1'b0;
        cyc();
        bus.kick = '0; bus.en_wr = 1'b0;
        cyc();
        checks++;
        if (dut.cnt_q[3] !== 32'd0) begin errors++; $display("FAIL prio_dis_kick: got cnt=%0d expected 0", dut.cnt_q[3]); end
        bus.kick = 4'b1000;
        cyc();
        bus.kick = '0;
        cyc();
        checks++;
        if (dut.cnt_q[3] !== 32'd0 || bus.expired[3] !== 1'b0) begin
            errors++; $display("FAIL kick_disabled: got cnt=%0d exp=%b expected 0 0", dut.cnt_q[3], bus.expired[3]);
        end
        wr_en(3, 1'b1);
        repeat (2) cyc();
        bus.kick = 4'b1000;
        cyc();
        bus.kick = '0;
        checks++;
        if (dut.cnt_q[3] !== 32'd0) begin errors++; $display("FAIL prio_kick_tick: got cnt=%0d expected 0", dut.cnt_q[3]); end
        cyc();
        checks++;
        if (dut.cnt_q[3] !== 32'd1) begin errors++; $display("FAIL prio_after_kick: got cnt=%0d expected 1", dut.cnt_q[3]); end
        wr_en(3, 1'b0);
    endtask

    task automatic test_thr_lower();
        wr_en(0, 1'b1);
        repeat (6) cyc();
        wr_thr(0, 3);
        checks++;
        if (dut.cnt_q[0] !== 32'd7 || bus.expired[0] !== 1'b0) begin
            errors++; $display("FAIL thr_lower_wr: got cnt=%0d exp=%b expected 7 0", dut.cnt_q[0], bus.expired[0]);
        end
        cyc();
        checks++;
        if (dut.cnt_q[0] !== 32'd3 || bus.expired[0] !== 1'b1) begin
            errors++; $display("FAIL thr_lower_exp: got cnt=%0d exp=%b expected 3 1", dut.cnt_q[0], bus.expired[0]);
        end
        wr_en(0, 1'b0);
        wr_thr(0, 0);
        wr_en(0, 1'b1);
        checks++;
        if (bus.expired[0] !== 1'b0) begin errors++; $display("FAIL thr0_enable: got %b expected 0", bus.expired[0]); end
        cyc();
        checks++;
        if (bus.expired[0] !== 1'b1 || dut.cnt_q[0] !== 32'd0) begin
            errors++; $display("FAIL thr0_first_tick: got exp=%b cnt=%0d expected 1 0", bus.expired[0], dut.cnt_q[0]);
        end
        wr_en(0, 1'b0);
    endtask

    task automatic test_rst_mid();
        wr_thr(1, 100);
        wr_en(1, 1'b1);
        wr_thr(0, 0);
        wr_en(0, 1'b1);
        repeat (3) cyc();
        checks++;
        if (bus.wto_irq[0] !== 1'b1 || dut.cnt_q[1] !== 32'd5) begin
            errors++; $display("FAIL rst_setup: got wto=%b cnt1=%0d expected 1 5", bus.wto_irq[0], dut.cnt_q[1]);
        end
        #2 rst2 = 1'b1;
        #1;
        checks++;
        if (bus.expired !== 4'b0000 || dut.cnt_q[1] !== 32'd0 || dut.thr_q[0] !== ONES || dut.thr_q[1] !== ONES) begin
            errors++; $display("FAIL rst2_async: got exp=%b cnt1=%0d thr0=%h thr1=%h expected 0000 0 ffffffff ffffffff",
                               bus.expired, dut.cnt_q[1], dut.thr_q[0], dut.thr_q[1]);
        end
        checks++;
        if (bus.wto_irq[0] !== 1'b1) begin errors++; $display("FAIL rst2_irq_latency: got %b expected 1", bus.wto_irq[0]); end
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (bus.wto_irq !== 4'b0000 || bus.warn_irq !== 4'b0000) begin
            errors++; $display("FAIL rst2_irq_drop: got wto=%b warn=%b expected 0000 0000", bus.wto_irq, bus.warn_irq);
        end
        cyc();
        rst2 = 1'b0;
        wr_thr(0, 0);
        wr_en(0, 1'b1);
        repeat (3) cyc();
        checks++;
        if (bus.wto_irq[0] !== 1'b1) begin errors++; $display("FAIL rst_setup2: got %b expected 1", bus.wto_irq[0]); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.wto_irq !== 4'b0000 || bus.warn_irq !== 4'b0000) begin
            errors++; $display("FAIL rst_immediate: got wto=%b warn=%b expected 0000 0000", bus.wto_irq, bus.warn_irq);
        end
        #2 rst = 1'b0;
        cyc();
        wr_en(0, 1'b0);
    endtask

`ifdef WDT_LOCK_EN
    task automatic test_lock();
        wr_thr(0, 20);
        wr_en(0, 1'b1);
        repeat (2) cyc();
        wr_thr(0, 1);
        wr_en(0, 1'b0);
        wr_warn(0, 0);
        wr_pre(8'd5);
        cyc();
        checks++;
        if (dut.cnt_q[0] !== 32'd7 || bus.expired[0] !== 1'b0 || dut.thr_q[0] !== 32'd20) begin
            errors++; $display("FAIL lock_writes: got cnt=%0d exp=%b thr=%0d expected 7 0 20", dut.cnt_q[0], bus.expired[0], dut.thr_q[0]);
        end
        checks++;
        if (dut.warn_q[0] !== 1'b0 || dut.pre_reload_q !== 8'd0) begin
            errors++; $display("FAIL lock_warn_pre: got warn=%b pre=%0d expected 0 0", dut.warn_q[0], dut.pre_reload_q);
        end
    endtask
`else
    task automatic test_no_lock();
        wr_thr(0, 20);
        wr_en(0, 1'b1);
        repeat (2) cyc();
        wr_thr(0, 1);
        checks++;
        if (dut.thr_q[0] !== 32'd1 || dut.cnt_q[0] !== 32'd3) begin
            errors++; $display("FAIL nolock_thr: got thr=%0d cnt=%0d expected 1 3", dut.thr_q[0], dut.cnt_q[0]);
        end
        cyc();
        checks++;
        if (bus.expired[0] !== 1'b1 || dut.cnt_q[0] !== 32'd1) begin
            errors++; $display("FAIL nolock_exp: got exp=%b cnt=%0d expected 1 1", bus.expired[0], dut.cnt_q[0]);
        end
        wr_en(0, 1'b0);
        checks++;
        if (bus.expired[0] !== 1'b0 || dut.cnt_q[0] !== 32'd0) begin
            errors++; $display("FAIL nolock_disable: got exp=%b cnt=%0d expected 0 0", bus.expired[0], dut.cnt_q[0]);
        end
        wr_pre(8'd5);
        checks++;
        if (dut.pre_reload_q !== 8'd5) begin errors++; $display("FAIL nolock_pre: got %0d expected 5", dut.pre_reload_q); end
        wr_pre(8'd0);
    endtask
`endif

    initial begin
        test_reset();
        test_expire_basic();
        test_kick_expired();
        test_warning();
        test_kick_periodic();
        test_priority();
        test_thr_lower();
        test_rst_mid();
`ifdef WDT_LOCK_EN
        test_lock();
`else
        test_no_lock();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wdt_multi_ch.md
Name: wdt_multi_ch

Overview:
- Multi-channel watchdog timer with a shared programmable prescaler.
- Each channel has a per-channel timeout threshold, an early-warning threshold and a sticky expiry state.
- Counting runs in the clk2 (slow/peripheral) domain. Warning and timeout levels are synchronised into the clk (CPU) domain as interrupt lines.
- Sits behind the peripheral register decoder, which drives the single-cycle write strobes.

Parameters:
- NUM_CH, 4: number of independent watchdog channels (1..16).
- CNT_W, 32: counter, threshold and warning width in bits (8..32).
- PRE_W, 8: prescaler reload width.
- SYNC_STAGES, 2: synchroniser depth into the clk domain (>=2).

Ports:
- clk2  input  1  counting clock
- rst2  input  1  asynchronous active-high reset, clk2 domain
- clk  input  1  CPU clock for interrupt synchronisers
- rst  input  1  asynchronous active-high reset, clk domain
- ch_sel  input  $clog2(NUM_CH)  channel targeted by en_wr/thr_wr/warn_wr
- en_wr  input  1  write strobe for enable bit
- en_val  input  1  enable value
- thr_wr  input  1  write strobe for timeout threshold
- warn_wr  input  1  write strobe for warning threshold
- wdata  input  CNT_W  threshold/warning data
- pre_wr  input  1  write strobe for prescaler reload
- pre_val  input  PRE_W  prescaler reload
- kick  input  NUM_CH  per-channel service pulse
- wto_irq  output  NUM_CH  timeout interrupt, clk domain
- warn_irq  output  NUM_CH  warning interrupt, clk domain
- expired  output  NUM_CH  raw expiry status, clk2 domain

Behaviour:
- Clocking and reset: reset rst2, asynchronous, active-high; clock clk2. The synchroniser flops use rst/clk.
- Reset values:
  - All channels DISABLED; counters 0; thresholds all-ones; warning thresholds all-ones; prescaler reload 0; prescaler count 0.
  - expired, wto_irq and warn_irq all 0.
- Prescaler (shared):
  - Down-counter; tick=1 for one clk2 cycle when count==0, then reloads pre_val_reg.
  - Reload 0 means a tick every cycle.
  - pre_wr updates the reload and restarts the count from the new value on the next cycle.
- Per-channel FSM:
  - DISABLED:
    - counter held at 0.
    - en_wr&&en_val&&ch_sel==i -> RUNNING, counter=0.
  - RUNNING:
    - On tick, counter+1.
    - On tick with counter+1 >= thr -> EXPIRED; counter holds at thr.
  - EXPIRED:
    - expired[i]=1; counter frozen.
    - kick[i] -> RUNNING with counter=0.
  - Any state: en_wr&&!en_val&&ch_sel==i -> DISABLED, counter=0, warning cleared.
- Warning:
  - warn_flag[i] set when in RUNNING and counter >= warn_thr (warn_thr < thr).
  - Cleared by kick[i] or disable.
  - Stays set in EXPIRED.
  - warn_thr >= thr means the warning never fires before expiry; it asserts together with expiry.
- Priority, same cycle:
  - disable > kick > tick.
  - Kick in RUNNING zeroes the counter and suppresses that cycle's increment.
  - Kick in DISABLED is ignored.
- Threshold writes:
  - Take effect the cycle after the strobe; comparison uses >=.
  - Lowering thr below the current counter expires the channel on the next tick.
  - thr=0 expires on the first tick after enable.
- Arithmetic: counter is never incremented past thr; no wrap-around.
- Interrupts:
  - expired[i] and warn_flag[i] are registered in clk2, then passed through SYNC_STAGES flops in clk.
  - Latency: 1 clk2 + SYNC_STAGES clk edges.
  - Both are levels held until kick/disable, so no pulse is lost across domains.
- Reset mid-operation:
  - rst2 returns all state to reset values immediately.
  - Interrupts drop after the synchroniser latency, or immediately on rst.

Optional Feature:
- Macro: WDT_LOCK_EN.
- When defined:
  - Per-channel lock bit is set when the channel enters RUNNING.
  - While locked, en_wr with en_val=0, thr_wr and warn_wr for that channel are ignored.
  - pre_wr is ignored once any channel is locked.
  - Locks clear only on rst2.
- When undefined: no lock; all writes are always accepted.

Test Plan:
- pre=0, thr=10, enable ch0, no kick -> expired[0]=1 on the 10th clk2 after enable; wto_irq[0]=1 two clk edges later.
- pre=3, thr=4, warn=2, enable ch1 -> warn_irq[1] rises after 8 clk2 cycles (+sync); expiry after 16 clk2 cycles.
- ch2 thr=5, kick every 4 ticks for 50 cycles -> expired[2] and wto_irq[2] stay 0; counter never exceeds 4.
- Kick and disable on the same cycle with ch3 at counter=3 -> ch3 DISABLED, counter=0; kick and tick together -> counter=0, not 1.
- Expire ch0, then kick -> expired[0]=0 next clk2, counter restarts at 0; assert rst2 mid-count on ch1 -> all outputs 0, thresholds all-ones.
- With WDT_LOCK_EN: enable ch0, write thr=1 and en_val=0 -> ignored; ch0 keeps its original threshold and keeps running.
